// File: rtl/hex_pkg.sv
// Shared types and constants for the hex scan counter.
// seg_t      : 7-bit segment vector, segment a in bit 0 through g in bit 6, active-high.
// SEG_GLYPH  : 16-entry hex glyph table (0-9, A, b, C, d, E, F).
// SEG_BLANK  : all segments off.
// hex_glyph(): table lookup helper.
package hex_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    localparam seg_t SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    function automatic seg_t hex_glyph(input logic [3:0] nib);
        return SEG_GLYPH[nib];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and emits a registered one-cycle
// pulse on the cycle after the terminal count is reached, then restarts at 0.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (counter and pulse cleared)
//   tick_o : one-cycle pulse every DIV cycles
module tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/hex_scan_counter.sv
// Up/down hex counter with a multiplexed 7-segment display driver.
// Optional build macro: HEX_LZB_EN enables leading-zero blanking (digit 0 never blanked).
// Ports:
//   CLK      : system clock
//   RST      : asynchronous active-high reset
//   en       : count enable (also drives the pause indicator on dp)
//   up       : 1 = increment, 0 = decrement
//   load     : synchronous load strobe, takes priority over counting
//   load_val : load value (4*NDIGITS bits)
//   value    : current count
//   tick     : one-cycle pulse at TICK_HZ
//   seg      : segments a..g in bits 0..6, active-high, registered
//   dp       : decimal point, high while digit 0 is shown and en=0
//   dig_sel  : one-hot digit enable, registered together with seg
module hex_scan_counter
    import hex_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 12_000_000,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned NDIGITS  = 4,
    parameter int unsigned SCAN_HZ  = 1000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   en,
    input  logic                   up,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    output logic [4*NDIGITS-1:0]   value,
    output logic                   tick,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NDIGITS-1:0]     dig_sel
);

    localparam int unsigned W  = 4 * NDIGITS;
    localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

    // Clamp dividers to at least 1 so odd parameter sets still elaborate.
    localparam int unsigned TICK_DIV_RAW = CLK_FREQ / TICK_HZ;
    localparam int unsigned SCAN_DIV_RAW = CLK_FREQ / (SCAN_HZ * NDIGITS);
    localparam int unsigned TICK_DIV = (TICK_DIV_RAW > 0) ? TICK_DIV_RAW : 1;
    localparam int unsigned SCAN_DIV = (SCAN_DIV_RAW > 0) ? SCAN_DIV_RAW : 1;

    logic               count_tick;
    logic               scan_tick;

    logic [W-1:0]       value_q, value_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NDIGITS-1:0] dig_sel_q, dig_sel_d;
    seg_t               seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [3:0]         nib;
    logic [IW-1:0]      msd;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_count_tick (
        .clk_i  (CLK),
        .rst_i  (RST),
        .tick_o (count_tick)
    );

    tick_gen #(
        .DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk_i  (CLK),
        .rst_i  (RST),
        .tick_o (scan_tick)
    );

    // Count update: load beats a coincident tick.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (count_tick && en) begin
            value_d = up ? value_q + W'(1) : value_q - W'(1);
        end
    end

    // Scan index; with NDIGITS=1 LAST_IDX is 0 so the index stays at 0.
    always_comb begin
        idx_d = idx_q;
        if (scan_tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
    end

    // Display outputs are computed from the next index so dig_sel and seg
    // change on the same edge and the glyph always matches the lit digit.
    always_comb begin
        nib       = 4'h0;
        msd       = '0;
        dig_sel_d = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            dig_sel_d[i] = (idx_d == IW'(i));
            if (idx_d == IW'(i)) begin
                nib = value_q[4*i +: 4];
            end
            if (value_q[4*i +: 4] != 4'h0) begin
                msd = IW'(i);
            end
        end
`ifdef HEX_LZB_EN
        seg_d = (idx_d > msd) ? SEG_BLANK : hex_glyph(nib);
`else
        seg_d = hex_glyph(nib);
`endif
        dp_d = (idx_d == '0) && !en;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value_q   <= '0;
            idx_q     <= '0;
            dig_sel_q <= NDIGITS'(1);
            seg_q     <= SEG_GLYPH[0];
            dp_q      <= 1'b0;
        end else begin
            value_q   <= value_d;
            idx_q     <= idx_d;
            dig_sel_q <= dig_sel_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign value   = value_q;
    assign tick    = count_tick;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign dig_sel = dig_sel_q;

`ifndef HEX_LZB_EN
    logic unused_msd;
    assign unused_msd = ^msd;
`endif

endmodule

// File: doc/hex_scan_counter.md
HEX_SCAN_COUNTER -- requirements
Module: hex_scan_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter CLK_FREQ, 12_000_000, CLK frequency in Hz.
REQ-003 Parameter TICK_HZ, 1, count-tick rate in Hz.
REQ-004 Parameter NDIGITS, 4, number of hex digits (1..8).
REQ-005 Parameter SCAN_HZ, 1000, full display refresh rate in Hz.
REQ-006 Port CLK  in  1  system clock.
REQ-007 Port RST  in  1  asynchronous active-high reset.
REQ-008 Port en  in  1  count enable.
REQ-009 Port up  in  1  direction: 1 = increment, 0 = decrement.
REQ-010 Port load  in  1  synchronous load strobe.
REQ-011 Port load_val  in  4*NDIGITS  load value.
REQ-012 Port value  out  4*NDIGITS  current count.
REQ-013 Port tick  out  1  one-cycle pulse at TICK_HZ.
REQ-014 Port seg  out  7  segments a..g in bits 0..6, active-high.
REQ-015 Port dp  out  1  decimal point, active-high.
REQ-016 Port dig_sel  out  NDIGITS  one-hot digit enable, active-high.

Function
REQ-017 Tick prescaler SHALL count 0..CLK_FREQ/TICK_HZ-1, pulse tick for exactly one cycle at the terminal count, then restart at 0.
REQ-018 Prescaler SHALL run regardless of en.
REQ-019 The count update SHALL use fixed priority: load first (value <= load_val, even when en=0), then tick && en (±1 per up), else hold.
REQ-020 Count arithmetic SHALL wrap modulo 2^(4*NDIGITS): all-ones +1 -> 0, 0 -1 -> all-ones.
REQ-021 load coinciding with tick SHALL load load_val and discard the step.
REQ-022 Scan prescaler SHALL advance the digit index every CLK_FREQ/(SCAN_HZ*NDIGITS) cycles, wrapping from NDIGITS-1 to 0.
REQ-023 dig_sel and seg SHALL be registered and update on the same edge.
REQ-024 seg SHALL show the hex glyph (0-9, A, b, C, d, E, F) of the value nibble selected by the new index, sampled one cycle earlier.
REQ-025 dp SHALL be 1 only while digit 0 is selected and en=0, as a pause indicator.
REQ-026 When NDIGITS=1, the scan index SHALL remain 0 and dig_sel SHALL be constantly 1.

Reset
REQ-027 On RST, asynchronously: value=0, tick=0, both prescalers=0, digit index=0, dig_sel=1 (digit 0 only), seg=7'h3F (glyph 0), dp=0.
REQ-028 Deassertion SHALL restart both prescalers from 0; a tick count in progress is lost.

Configuration
REQ-029 Macro HEX_LZB_EN SHALL enable leading-zero blanking: a selected digit above the most significant non-zero nibble drives seg=0; digit 0 is never blanked.
REQ-030 Without HEX_LZB_EN, all digits SHALL always show their glyph.

Structure
REQ-031 Package hex_pkg SHALL hold the seg_t typedef (logic [6:0]), the 16-entry glyph table, and the SEG_BLANK constant.
REQ-032 Sub-module tick_gen (parameter DIV, output one-cycle pulse) SHALL be instantiated twice, once for the count tick and once for the scan.

Verification (CLK_FREQ=100, TICK_HZ=10, SCAN_HZ=5, NDIGITS=4 -> tick every 10 cycles, scan step every 5)
REQ-033 Release RST, en=1, up=1 -> tick high on cycles 10, 20, ...; value 0x0001 after first tick, 0x0003 after third.
REQ-034 load_val=0xFFFF load, up=1 -> value 0x0000 after next tick; up=0 from 0x0000 -> 0xFFFF.
REQ-035 load=1 on tick cycle with load_val=0x1234 -> value=0x1234, no increment.
REQ-036 value=0x00A5 -> dig_sel cycles 0001,0010,0100,1000 every 5 cycles; seg 0x6D, 0x77, 0x3F, 0x3F (with HEX_LZB_EN: 0x6D, 0x77, 0x00, 0x00).
REQ-037 en=0 -> value frozen, dp=1 only when dig_sel=0001; assert RST mid-scan -> dig_sel=0001, seg=0x3F immediately.
